// File: rtl/gmii_frame_relay.sv
// GMII relay stage: fixed-latency rx->tx passthrough, plus burst parsing with a
// framed tap stream and saturating frame/error statistics.
module gmii_frame_relay #(
  parameter int unsigned DELAY   = 4,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522
) (
  input  logic        clk_125,
  input  logic        reset,
  input  logic [7:0]  rx_d,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  tx_d,
  output logic        tx_en,
  output logic        tx_er,
  output logic [7:0]  tap_data,
  output logic        tap_valid,
  output logic        tap_sof,
  output logic        tap_eof,
  output logic        tap_err,
  input  logic        clear_stats,
  output logic [15:0] frame_count,
  output logic [15:0] error_count,
  output logic [10:0] last_len
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_BAD} state_e;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

  logic [DELAY-1:0][9:0] dly_q;

  state_e      state_q, state_d;
  logic        dv_q;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] len_q;
  logic        err_q;
  logic [7:0]  stage_q;
  logic        stage_v_q, stage_sof_q;
  logic [7:0]  tap_data_q;
  logic        tap_valid_q, tap_sof_q, tap_eof_q, tap_err_q;
  logic [15:0] frame_count_q, error_count_q;
  logic [10:0] last_len_q;

  logic        rise, pre_abort, enter_bad, frame_end, frame_bad, err_inc;
  logic [10:0] len_nxt;

  always_ff @(posedge clk_125) begin
    if (reset) begin
      dly_q <= '0;
    end else begin
      dly_q <= {dly_q[DELAY-2:0], {rx_d, rx_dv, rx_er}};
    end
  end

  assign {tx_d, tx_en, tx_er} = dly_q[DELAY-1];

  assign rise = rx_dv && !dv_q;

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    pre_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          if (rx_d == PRE_BYTE) begin
            state_d   = S_PRE;
            pre_cnt_d = 3'd1;
          end else if (rx_d == SFD_BYTE) begin
            state_d = S_DATA;
          end else begin
            state_d = S_BAD;
          end
        end
      end
      S_PRE: begin
        if (!rx_dv) begin
          state_d   = S_IDLE;
          pre_abort = 1'b1;
        end else if (rx_er) begin
          state_d = S_BAD;
        end else if (rx_d == PRE_BYTE) begin
          if (pre_cnt_q == 3'd7) state_d = S_BAD;
          else                   pre_cnt_d = pre_cnt_q + 3'd1;
        end else if (rx_d == SFD_BYTE) begin
          state_d = S_DATA;
        end else begin
          state_d = S_BAD;
        end
      end
      S_DATA:  if (!rx_dv) state_d = S_IDLE;
      S_BAD:   if (!rx_dv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_bad = (state_d == S_BAD) && (state_q != S_BAD);
  assign frame_end = (state_q == S_DATA) && !rx_dv;
  assign frame_bad = err_q || (len_q < MIN_L) || (len_q > MAX_L);
  assign err_inc   = enter_bad || pre_abort || (frame_end && frame_bad);
  assign len_nxt   = (len_q == '1) ? len_q : len_q + 11'd1;

  always_ff @(posedge clk_125) begin
    if (reset) begin
      state_q       <= S_IDLE;
      dv_q          <= 1'b1;
      pre_cnt_q     <= '0;
      len_q         <= '0;
      err_q         <= 1'b0;
      stage_q       <= '0;
      stage_v_q     <= 1'b0;
      stage_sof_q   <= 1'b0;
      tap_data_q    <= '0;
      tap_valid_q   <= 1'b0;
      tap_sof_q     <= 1'b0;
      tap_eof_q     <= 1'b0;
      tap_err_q     <= 1'b0;
      frame_count_q <= '0;
      error_count_q <= '0;
      last_len_q    <= '0;
    end else begin
      state_q   <= state_d;
      dv_q      <= rx_dv;
      pre_cnt_q <= pre_cnt_d;

      if (state_q != S_DATA && state_d == S_DATA) begin
        len_q <= '0;
        err_q <= 1'b0;
      end else if (state_q == S_DATA && rx_dv) begin
        len_q <= len_nxt;
        err_q <= err_q || rx_er;
      end

      // One-byte staging so the final byte can be tagged once rx_dv falls.
      if (state_q == S_DATA && rx_dv) begin
        stage_q     <= rx_d;
        stage_sof_q <= (len_q == '0);
        stage_v_q   <= 1'b1;
      end else begin
        stage_v_q   <= 1'b0;
      end

      tap_data_q  <= stage_q;
      tap_valid_q <= stage_v_q;
      tap_sof_q   <= stage_v_q && stage_sof_q;
      tap_eof_q   <= frame_end && stage_v_q;
      tap_err_q   <= frame_end && stage_v_q && frame_bad;

      if (frame_end) last_len_q <= len_q;

      if (clear_stats) begin
        frame_count_q <= '0;
      end else if (frame_end && frame_count_q != '1) begin
        frame_count_q <= frame_count_q + 16'd1;
      end

      if (clear_stats) begin
        error_count_q <= '0;
      end else if (err_inc && error_count_q != '1) begin
        error_count_q <= error_count_q + 16'd1;
      end
    end
  end

  assign tap_data    = tap_data_q;
  assign tap_valid   = tap_valid_q;
  assign tap_sof     = tap_sof_q;
  assign tap_eof     = tap_eof_q;
  assign tap_err     = tap_err_q;
  assign frame_count = frame_count_q;
  assign error_count = error_count_q;
  assign last_len    = last_len_q;

endmodule

// File: tb/tb_gmii_frame_relay.sv
// Self-checking bench for gmii_frame_relay: directed scenarios plus randomized
// bursts scored against a burst-level reference model.
module tb_gmii_frame_relay;

  localparam int unsigned DELAY   = 4;
  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 1522;

  logic        clk_125 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_d = '0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic        clear_stats = 1'b0;
  logic [7:0]  tx_d;
  logic        tx_en, tx_er;
  logic [7:0]  tap_data;
  logic        tap_valid, tap_sof, tap_eof, tap_err;
  logic [15:0] frame_count, error_count;
  logic [10:0] last_len;

  gmii_frame_relay #(.DELAY(DELAY), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk_125(clk_125), .reset(reset), .rx_d(rx_d), .rx_dv(rx_dv), .rx_er(rx_er),
    .tx_d(tx_d), .tx_en(tx_en), .tx_er(tx_er),
    .tap_data(tap_data), .tap_valid(tap_valid), .tap_sof(tap_sof),
    .tap_eof(tap_eof), .tap_err(tap_err), .clear_stats(clear_stats),
    .frame_count(frame_count), .error_count(error_count), .last_len(last_len)
  );

  always #5 clk_125 = ~clk_125;

  int checks = 0;
  int errors = 0;
  int tx_mis = 0;

  logic [7:0]  burst_d[$];
  logic        burst_er[$];
  logic [10:0] exp_taps[$];
  logic [10:0] obs_taps[$];
  logic [15:0] exp_fc = '0;
  logic [15:0] exp_ec = '0;
  logic [10:0] exp_ll = '0;

  // tx must equal the rx vector captured DELAY-1 edges earlier, or zero while
  // the line still holds post-reset fill.
  int         k = 0;
  int         last_rst = 0;
  bit         rst_next = 1'b1;
  logic [9:0] rxh [64];
  logic [9:0] exp_tx;
  int         e;

  always @(negedge clk_125) begin
    k = k + 1;
    if (rst_next) last_rst = k;
    e = k - int'(DELAY) + 1;
    exp_tx = (e > last_rst) ? rxh[e % 64] : '0;
    if ({tx_d, tx_en, tx_er} !== exp_tx) tx_mis = tx_mis + 1;
    rxh[(k + 1) % 64] = {rx_d, rx_dv, rx_er};
    rst_next = reset;
    if (tap_valid) obs_taps.push_back({tap_data, tap_sof, tap_eof, tap_err & tap_eof});
  end

  // Burst-level reference: classify the preamble, then derive tap beats and stats.
  task automatic model_burst(input bit clr);
    int n, sz, len;
    bit bad;
    n = 0;
    sz = burst_d.size();
    while (n < sz && burst_d[n] == 8'h55) n++;
    if (n >= 8 || n == sz || burst_d[n] != 8'hD5) begin
      if (exp_ec != 16'hFFFF) exp_ec++;
    end else begin
      len = sz - n - 1;
      bad = (len < int'(MIN_LEN)) || (len > int'(MAX_LEN));
      for (int i = n + 1; i < sz; i++) if (burst_er[i]) bad = 1'b1;
      for (int j = 0; j < len; j++)
        exp_taps.push_back({burst_d[n + 1 + j], (j == 0), (j == len - 1), ((j == len - 1) && bad)});
      if (exp_fc != 16'hFFFF) exp_fc++;
      if (bad && exp_ec != 16'hFFFF) exp_ec++;
      exp_ll = (len > 2047) ? 11'd2047 : 11'(len);
    end
    if (clr) begin
      exp_fc = '0;
      exp_ec = '0;
    end
  endtask

  task automatic build_frame(input int npre, input int ndata, input int er_idx);
    burst_d.delete();
    burst_er.delete();
    for (int i = 0; i < npre; i++) begin burst_d.push_back(8'h55); burst_er.push_back(1'b0); end
    burst_d.push_back(8'hD5);
    burst_er.push_back(1'b0);
    for (int i = 0; i < ndata; i++) begin
      burst_d.push_back(8'(i));
      burst_er.push_back(i == er_idx);
    end
  endtask

  task automatic send_burst(input int gap, input bit clr);
    for (int i = 0; i < burst_d.size(); i++) begin
      @(posedge clk_125); #1;
      rx_dv = 1'b1; rx_d = burst_d[i]; rx_er = burst_er[i];
    end
    @(posedge clk_125); #1;
    rx_dv = 1'b0; rx_er = 1'b0; rx_d = 8'h00; clear_stats = clr;
    @(posedge clk_125); #1;
    clear_stats = 1'b0;
    for (int i = 1; i < gap; i++) @(posedge clk_125);
    model_burst(clr);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk_125);
    @(negedge clk_125);
  endtask

  function automatic int first_diff();
    int n;
    n = (exp_taps.size() < obs_taps.size()) ? exp_taps.size() : obs_taps.size();
    for (int i = 0; i < n; i++) if (exp_taps[i] !== obs_taps[i]) return i;
    if (exp_taps.size() != obs_taps.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge clk_125);
    checks++;
    if ({tx_d, tx_en, tx_er, tap_data, tap_valid, tap_sof, tap_eof, tap_err,
         frame_count, error_count, last_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tx=%h tap=%h/%b%b%b%b fc=%0d ec=%0d len=%0d, want all 0",
               tx_d, tap_data, tap_valid, tap_sof, tap_eof, tap_err, frame_count, error_count, last_len);
    end
  endtask

  task automatic test_min_frame();
    int d;
    build_frame(7, 64, -1);
    send_burst(2, 1'b0);
    settle();
    checks++;
    d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL min_taps: beat %0d got %h want %h (beats got %0d want %0d)",
               d, obs_taps[d], exp_taps[d], obs_taps.size(), exp_taps.size());
    end
    exp_taps.delete(); obs_taps.delete();
    checks++;
    if ({frame_count, error_count, last_len} !== {16'd1, 16'd0, 11'd64}) begin
      errors++;
      $display("FAIL min_stats: got fc=%0d ec=%0d len=%0d, want fc=1 ec=0 len=64",
               frame_count, error_count, last_len);
    end
    checks++;
    if (tx_mis !== 0) begin errors++; $display("FAIL min_tx_mirror: got %0d bad tx cycles, want 0", tx_mis); end
  endtask

  task automatic test_runt_giant();
    build_frame(7, 60, -1);
    send_burst(2, 1'b0);
    settle();
    checks++;
    if ({error_count, last_len} !== {exp_ec, exp_ll} || last_len !== 11'd60 || obs_taps[59] !== exp_taps[59]) begin
      errors++;
      $display("FAIL runt: got ec=%0d len=%0d last beat %h, want ec=%0d len=60 last beat %h",
               error_count, last_len, obs_taps[59], exp_ec, exp_taps[59]);
    end
    exp_taps.delete(); obs_taps.delete();
    build_frame(7, 1523, -1);
    send_burst(2, 1'b0);
    settle();
    checks++;
    if ({frame_count, error_count, last_len} !== {exp_fc, exp_ec, 11'd1523} || first_diff() != -1) begin
      errors++;
      $display("FAIL giant: got fc=%0d ec=%0d len=%0d taps_diff=%0d, want fc=%0d ec=%0d len=1523 taps_diff=-1",
               frame_count, error_count, last_len, first_diff(), exp_fc, exp_ec);
    end
    exp_taps.delete(); obs_taps.delete();
  endtask

  task automatic test_rx_er();
    int d;
    build_frame(7, 100, 10);
    send_burst(2, 1'b0);
    settle();
    checks++;
    d = first_diff();
    if (d != -1 || obs_taps.size() != 100 || obs_taps[99][0] !== 1'b1) begin
      errors++;
      $display("FAIL rxer_taps: beat %0d got %h want %h (beats got %0d want 100, eof err must be 1)",
               d, obs_taps[d], exp_taps[d], obs_taps.size());
    end
    exp_taps.delete(); obs_taps.delete();
    checks++;
    if ({frame_count, error_count, last_len} !== {exp_fc, exp_ec, exp_ll}) begin
      errors++;
      $display("FAIL rxer_stats: got fc=%0d ec=%0d len=%0d, want fc=%0d ec=%0d len=%0d",
               frame_count, error_count, last_len, exp_fc, exp_ec, exp_ll);
    end
    checks++;
    if (tx_mis !== 0) begin errors++; $display("FAIL rxer_tx_mirror: got %0d bad tx cycles, want 0", tx_mis); end
  endtask

  task automatic test_bad_preamble();
    burst_d = '{8'h55, 8'h55, 8'h54};
    burst_er = '{1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin burst_d.push_back(8'($urandom)); burst_er.push_back(1'b0); end
    send_burst(2, 1'b0);
    settle();
    checks++;
    if (obs_taps.size() != 0) begin
      errors++;
      $display("FAIL badpre_taps: got %0d tap beats, want 0", obs_taps.size());
    end
    obs_taps.delete();
    checks++;
    if ({frame_count, error_count} !== {exp_fc, exp_ec}) begin
      errors++;
      $display("FAIL badpre_stats: got fc=%0d ec=%0d, want fc=%0d ec=%0d",
               frame_count, error_count, exp_fc, exp_ec);
    end
    checks++;
    if (tx_mis !== 0) begin errors++; $display("FAIL badpre_tx_mirror: got %0d bad tx cycles, want 0", tx_mis); end
  endtask

  task automatic test_back_to_back();
    int d;
    build_frame(7, 64, -1);  send_burst(1, 1'b0);
    build_frame(0, 10, -1);  send_burst(1, 1'b0);
    build_frame(3, 1, -1);   send_burst(1, 1'b0);
    settle();
    checks++;
    d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL b2b_taps: beat %0d got %h want %h (beats got %0d want %0d)",
               d, obs_taps[d], exp_taps[d], obs_taps.size(), exp_taps.size());
    end
    exp_taps.delete(); obs_taps.delete();
    checks++;
    if ({frame_count, error_count, last_len} !== {exp_fc, exp_ec, exp_ll}) begin
      errors++;
      $display("FAIL b2b_stats: got fc=%0d ec=%0d len=%0d, want fc=%0d ec=%0d len=%0d",
               frame_count, error_count, last_len, exp_fc, exp_ec, exp_ll);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_125); #1;
      rx_dv = 1'b1; rx_er = 1'b0; rx_d = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_125); #1;
      rx_d = 8'(i); reset = (i == 30);
      if (i == 31) begin
        @(negedge clk_125);
        checks++;
        if ({tx_d, tx_en, tx_er, tap_data, tap_valid, tap_sof, tap_eof, tap_err,
             frame_count, error_count, last_len} !== '0) begin
          errors++;
          $display("FAIL midreset_outputs: got tx=%h tap=%h/%b fc=%0d ec=%0d len=%0d, want all 0",
                   tx_d, tap_data, tap_valid, frame_count, error_count, last_len);
        end
      end
    end
    @(posedge clk_125); #1;
    rx_dv = 1'b0; rx_d = 8'h00;
    exp_fc = '0; exp_ec = '0; exp_ll = '0;
    for (int j = 0; j < 29; j++) exp_taps.push_back({8'(j), (j == 0), 1'b0, 1'b0});
    settle();
    checks++;
    d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL midreset_taps: beat %0d got %h want %h (beats got %0d want %0d)",
               d, obs_taps[d], exp_taps[d], obs_taps.size(), exp_taps.size());
    end
    exp_taps.delete(); obs_taps.delete();
    build_frame(7, 64, -1);
    send_burst(2, 1'b0);
    settle();
    exp_taps.delete(); obs_taps.delete();
    checks++;
    if ({frame_count, error_count, last_len} !== {16'd1, 16'd0, 11'd64}) begin
      errors++;
      $display("FAIL midreset_next: got fc=%0d ec=%0d len=%0d, want fc=1 ec=0 len=64",
               frame_count, error_count, last_len);
    end
    checks++;
    if (tx_mis !== 0) begin errors++; $display("FAIL midreset_tx_mirror: got %0d bad tx cycles, want 0", tx_mis); end
  endtask

  task automatic test_clear_sat();
    build_frame(7, 20, -1);
    send_burst(2, 1'b0);
    build_frame(7, 64, -1);
    send_burst(2, 1'b1);
    settle();
    exp_taps.delete(); obs_taps.delete();
    checks++;
    if ({frame_count, error_count, last_len} !== {16'd0, 16'd0, 11'd64}) begin
      errors++;
      $display("FAIL clear_eof: got fc=%0d ec=%0d len=%0d, want fc=0 ec=0 len=64",
               frame_count, error_count, last_len);
    end
    @(negedge clk_125);
    force dut.frame_count_q = 16'hFFFF;
    force dut.error_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    release dut.error_count_q;
    exp_fc = 16'hFFFF; exp_ec = 16'hFFFF;
    build_frame(7, 10, -1);
    send_burst(2, 1'b0);
    settle();
    exp_taps.delete(); obs_taps.delete();
    checks++;
    if ({frame_count, error_count, last_len} !== {16'hFFFF, 16'hFFFF, 11'd10}) begin
      errors++;
      $display("FAIL saturate: got fc=%h ec=%h len=%0d, want fc=ffff ec=ffff len=10",
               frame_count, error_count, last_len);
    end
    clear_stats = 1'b1;
    @(posedge clk_125); #1;
    clear_stats = 1'b0;
    exp_fc = '0; exp_ec = '0;
  endtask

  task automatic test_random();
    int kind, npre, ndata, d;
    logic [7:0] b;
    for (int t = 0; t < 30; t++) begin
      burst_d.delete(); burst_er.delete();
      kind = $urandom_range(0, 9);
      npre = (kind == 6) ? $urandom_range(8, 9) : (kind == 8) ? $urandom_range(1, 7) : $urandom_range(0, 7);
      for (int i = 0; i < npre; i++) begin burst_d.push_back(8'h55); burst_er.push_back(1'b0); end
      if (kind != 8) begin
        if (kind == 7) begin
          do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
          burst_d.push_back(b);
        end else begin
          burst_d.push_back(8'hD5);
        end
        burst_er.push_back(1'b0);
        ndata = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : $urandom_range(40, 90);
        for (int i = 0; i < ndata; i++) begin
          burst_d.push_back(8'($urandom));
          burst_er.push_back($urandom_range(0, 24) == 0);
        end
      end
      send_burst($urandom_range(1, 3), 1'b0);
      if (t == 29 || $urandom_range(0, 2) != 0) begin
        settle();
        checks++;
        d = first_diff();
        if (d != -1) begin
          errors++;
          $display("FAIL rand_taps[%0d]: beat %0d got %h want %h (beats got %0d want %0d)",
                   t, d, obs_taps[d], exp_taps[d], obs_taps.size(), exp_taps.size());
        end
        exp_taps.delete(); obs_taps.delete();
        checks++;
        if ({frame_count, error_count, last_len} !== {exp_fc, exp_ec, exp_ll}) begin
          errors++;
          $display("FAIL rand_stats[%0d]: got fc=%0d ec=%0d len=%0d, want fc=%0d ec=%0d len=%0d",
                   t, frame_count, error_count, last_len, exp_fc, exp_ec, exp_ll);
        end
      end
    end
    checks++;
    if (tx_mis !== 0) begin errors++; $display("FAIL rand_tx_mirror: got %0d bad tx cycles, want 0", tx_mis); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk_125);
    #1;
    reset = 1'b0;
    test_reset();
    test_min_frame();
    test_runt_giant();
    test_rx_er();
    test_bad_preamble();
    test_back_to_back();
    test_reset_mid();
    test_clear_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
